// File: rtl/lsu_dcache.sv
// lsu_dcache: 4-way, 16-set, 64 B-line write-back / write-allocate data cache.
// A controller FSM sequences lookups, dirty-victim write-back bursts and refill
// bursts. The tag array is held in flops and is cleared on reset. The data SRAM
// has a one-cycle read latency and is not reset.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for an LSU request; latch address, strobe and data
// LOOKUP    | compare tags; on a read hit, issue the SRAM read
// WB_RD     | read victim word k out of the SRAM
// WB_SEND   | present victim word k on the write-back channel until accepted
// REFILL    | accept 8 refill beats into the victim way, then write the tag
// HIT_RD    | capture the SRAM word into lsu_r_data
// HIT_WR    | strobed SRAM write and set the dirty bit
// RESP      | hold the acknowledge until the request drops
module lsu_dcache (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_r_ready,
  output logic [63:0] lsu_r_data,
  output logic        lsu_r_valid,
  input  logic        lsu_w_valid,
  input  logic [7:0]  lsu_w_strb,
  input  logic [63:0] lsu_w_data,
  output logic        lsu_w_ready,
  output logic [31:0] mem_r_addr,
  output logic        mem_r_ready,
  output logic [2:0]  mem_r_size,
  output logic [1:0]  mem_r_burst,
  output logic [7:0]  mem_r_len,
  input  logic        mem_r_valid,
  input  logic [63:0] mem_r_data,
  output logic [31:0] mem_w_addr,
  output logic        mem_w_valid,
  output logic [2:0]  mem_w_size,
  output logic [1:0]  mem_w_burst,
  output logic [7:0]  mem_w_len,
  output logic [7:0]  mem_w_strb,
  output logic [63:0] mem_w_data,
  input  logic        mem_w_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB_RD, S_WB_SEND, S_REFILL, S_HIT_RD, S_HIT_WR, S_RESP
  } state_t;

  state_t      state, state_nxt;
  logic [31:3] addr_q;
  logic [7:0]  strb_q;
  logic [63:0] wdata_q;
  logic        is_wr_q;
  logic [1:0]  way_q;
  logic [2:0]  beat_q;

  logic [23:0] tag_arr [4][16];
  logic [1:0]  rr_ptr [16];
  logic [63:0] sram [512];
  logic [63:0] sram_q;

  logic [3:0]  idx;
  logic [21:0] tag;
  logic        req;
  logic        hit, inv_found, vic_dirty;
  logic [1:0]  hit_way, inv_way, vic_way;
  logic        last_refill_beat;

  logic        sram_re, sram_we;
  logic [8:0]  sram_ra, sram_wa;
  logic [7:0]  sram_wstrb;
  logic [63:0] sram_wd;
  logic        tag_we;
  logic [23:0] tag_wd;

  assign idx = addr_q[9:6];
  assign tag = addr_q[31:10];
  assign req = lsu_w_valid | lsu_r_ready;
  assign last_refill_beat = (state == S_REFILL) && mem_r_valid && (beat_q == 3'd7);

  assign mem_r_size  = 3'd3;
  assign mem_r_burst = 2'b01;
  assign mem_r_len   = 8'd7;
  assign mem_w_size  = 3'd3;
  assign mem_w_burst = 2'b01;
  assign mem_w_len   = 8'd7;
  assign mem_w_strb  = 8'hFF;

  // Tag compare and victim choice: lowest invalid way, else round-robin pointer
  always_comb begin
    hit       = 1'b0;
    hit_way   = 2'd0;
    inv_found = 1'b0;
    inv_way   = 2'd0;
    for (int w = 3; w >= 0; w--) begin
      if (tag_arr[w][idx][23] && (tag_arr[w][idx][21:0] == tag)) begin
        hit     = 1'b1;
        hit_way = w[1:0];
      end
      if (!tag_arr[w][idx][23]) begin
        inv_found = 1'b1;
        inv_way   = w[1:0];
      end
    end
    vic_way   = inv_found ? inv_way : rr_ptr[idx];
    vic_dirty = tag_arr[vic_way][idx][23] & tag_arr[vic_way][idx][22];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (req) state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (hit)            state_nxt = is_wr_q ? S_HIT_WR : S_HIT_RD;
        else if (vic_dirty) state_nxt = S_WB_RD;
        else                state_nxt = S_REFILL;
      end
      S_WB_RD:   state_nxt = S_WB_SEND;
      S_WB_SEND: if (mem_w_ready) state_nxt = (beat_q == 3'd7) ? S_REFILL : S_WB_RD;
      S_REFILL:  if (last_refill_beat) state_nxt = S_LOOKUP;
      S_HIT_RD:  state_nxt = S_RESP;
      S_HIT_WR:  state_nxt = S_RESP;
      S_RESP:    if (!(is_wr_q ? lsu_w_valid : lsu_r_ready)) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs and SRAM / tag-array controls decoded from the current state
  always_comb begin
    lsu_r_valid = (state == S_RESP) && !is_wr_q;
    lsu_w_ready = (state == S_RESP) && is_wr_q;
    mem_r_ready = (state == S_REFILL);
    mem_r_addr  = (state == S_REFILL) ? {addr_q[31:6], 6'b0} : 32'd0;
    mem_w_valid = (state == S_WB_SEND);
    mem_w_data  = (state == S_WB_SEND) ? sram_q : 64'd0;
    mem_w_addr  = ((state == S_WB_RD) || (state == S_WB_SEND)) ?
                  {tag_arr[way_q][idx][21:0], idx, 6'b0} : 32'd0;
    sram_re     = 1'b0;
    sram_ra     = {way_q, idx, beat_q};
    sram_we     = 1'b0;
    sram_wa     = {way_q, idx, beat_q};
    sram_wstrb  = 8'hFF;
    sram_wd     = mem_r_data;
    tag_we      = 1'b0;
    tag_wd      = {2'b10, tag};
    case (state)
      S_LOOKUP: if (hit && !is_wr_q) begin
        sram_re = 1'b1;
        sram_ra = {hit_way, idx, addr_q[5:3]};
      end
      S_WB_RD:  sram_re = 1'b1;
      S_REFILL: begin
        sram_we = mem_r_valid;
        tag_we  = last_refill_beat;
      end
      S_HIT_WR: begin
        sram_we    = 1'b1;
        sram_wa    = {way_q, idx, addr_q[5:3]};
        sram_wstrb = strb_q;
        sram_wd    = wdata_q;
        tag_we     = 1'b1;
        tag_wd     = {2'b11, tag};
      end
      default: ;
    endcase
  end

  // Request capture, way/beat bookkeeping and read-data register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      strb_q     <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      way_q      <= '0;
      beat_q     <= '0;
      lsu_r_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          addr_q  <= lsu_addr[31:3];
          strb_q  <= lsu_w_strb;
          wdata_q <= lsu_w_data;
          is_wr_q <= lsu_w_valid;
        end
        S_LOOKUP: begin
          way_q  <= hit ? hit_way : vic_way;
          beat_q <= 3'd0;
        end
        S_WB_SEND: if (mem_w_ready) beat_q <= beat_q + 3'd1;
        S_REFILL:  if (mem_r_valid) beat_q <= beat_q + 3'd1;
        S_HIT_RD:  lsu_r_data <= sram_q;
        default: ;
      endcase
    end
  end

  // Tag array and per-set round-robin pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < 4; w++)
        for (int s = 0; s < 16; s++)
          tag_arr[w][s] <= '0;
      for (int s = 0; s < 16; s++)
        rr_ptr[s] <= '0;
    end else begin
      if (tag_we) tag_arr[way_q][idx] <= tag_wd;
      if (last_refill_beat) rr_ptr[idx] <= rr_ptr[idx] + 2'd1;
    end
  end

  // Data SRAM: registered read port, byte-strobed write port
  always_ff @(posedge clk) begin
    if (sram_re) sram_q <= sram[sram_ra];
    if (sram_we)
      for (int b = 0; b < 8; b++)
        if (sram_wstrb[b]) sram[sram_wa][8*b +: 8] <= sram_wd[8*b +: 8];
  end

endmodule

// File: tb/tb_lsu_dcache.sv
// Bench for lsu_dcache: directed LSU accesses against a flat memory model.
// gm holds the LSU-visible contents, bk the backing memory behind the cache.
module tb_lsu_dcache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lsu_addr = '0;
  logic        lsu_r_ready = 1'b0;
  logic [63:0] lsu_r_data;
  logic        lsu_r_valid;
  logic        lsu_w_valid = 1'b0;
  logic [7:0]  lsu_w_strb = '0;
  logic [63:0] lsu_w_data = '0;
  logic        lsu_w_ready;
  logic [31:0] mem_r_addr;
  logic        mem_r_ready;
  logic [2:0]  mem_r_size;
  logic [1:0]  mem_r_burst;
  logic [7:0]  mem_r_len;
  logic        mem_r_valid = 1'b0;
  logic [63:0] mem_r_data = '0;
  logic [31:0] mem_w_addr;
  logic        mem_w_valid;
  logic [2:0]  mem_w_size;
  logic [1:0]  mem_w_burst;
  logic [7:0]  mem_w_len;
  logic [7:0]  mem_w_strb;
  logic [63:0] mem_w_data;
  logic        mem_w_ready = 1'b0;

  lsu_dcache dut (
    .clk(clk), .rst(rst),
    .lsu_addr(lsu_addr), .lsu_r_ready(lsu_r_ready), .lsu_r_data(lsu_r_data),
    .lsu_r_valid(lsu_r_valid), .lsu_w_valid(lsu_w_valid), .lsu_w_strb(lsu_w_strb),
    .lsu_w_data(lsu_w_data), .lsu_w_ready(lsu_w_ready),
    .mem_r_addr(mem_r_addr), .mem_r_ready(mem_r_ready), .mem_r_size(mem_r_size),
    .mem_r_burst(mem_r_burst), .mem_r_len(mem_r_len), .mem_r_valid(mem_r_valid),
    .mem_r_data(mem_r_data), .mem_w_addr(mem_w_addr), .mem_w_valid(mem_w_valid),
    .mem_w_size(mem_w_size), .mem_w_burst(mem_w_burst), .mem_w_len(mem_w_len),
    .mem_w_strb(mem_w_strb), .mem_w_data(mem_w_data), .mem_w_ready(mem_w_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [63:0] gm [logic [31:0]];
  logic [63:0] bk [logic [31:0]];
  logic [31:0] rf_q[$];
  logic [31:0] wb_q[$];
  logic [31:0] cur_addr = '0;
  logic [63:0] wb_first = '0;
  logic [63:0] rd_last = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Untouched memory words hold {address, ~address}
  function automatic logic [63:0] bk_rd(input logic [31:0] a);
    if (bk.exists(a)) return bk[a];
    return {a, ~a};
  endfunction

  function automatic logic [63:0] gm_rd(input logic [31:0] a);
    if (gm.exists(a)) return gm[a];
    return bk_rd(a);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d,
                                        input logic [7:0] s);
    for (int b = 0; b < 8; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction

  // Memory responder and per-cycle compare against the model
  int stall_ctr = 0;
  int rbeat = 0, wbeat = 0;
  bit r_pending = 0, r_started = 0, w_pending = 0, w_started = 0;
  logic [31:0] r_lat_addr = '0, w_lat_addr = '0;
  logic [63:0] w_lat_data = '0;

  always @(negedge clk) begin
    stall_ctr++;
    chk("mem_r_size", 64'(mem_r_size), 64'd3);
    chk("mem_r_burst", 64'(mem_r_burst), 64'd1);
    chk("mem_r_len", 64'(mem_r_len), 64'd7);
    chk("mem_w_size", 64'(mem_w_size), 64'd3);
    chk("mem_w_burst", 64'(mem_w_burst), 64'd1);
    chk("mem_w_len", 64'(mem_w_len), 64'd7);
    chk("mem_w_strb", 64'(mem_w_strb), 64'hFF);
    chk("wb_rf_overlap", 64'(mem_r_ready & mem_w_valid), 64'd0);
    chk("ack_overlap", 64'(lsu_r_valid & lsu_w_ready), 64'd0);
    if (lsu_r_valid) chk("lsu_r_data", lsu_r_data, gm_rd({cur_addr[31:3], 3'b0}));

    if (!rst || !mem_r_ready) begin
      r_pending = 0; r_started = 0; rbeat = 0; mem_r_valid = 1'b0;
    end else begin
      if (r_pending) rbeat++;
      if (!r_started) begin
        r_started = 1; r_lat_addr = mem_r_addr; rf_q.push_back(mem_r_addr);
      end else chk("mem_r_addr_stable", 64'(mem_r_addr), 64'(r_lat_addr));
      mem_r_valid = (stall_ctr % 3 != 1) && (rbeat < 8);
      mem_r_data  = bk_rd(r_lat_addr + 32'(8 * rbeat));
      r_pending   = mem_r_valid;
    end

    if (w_pending) begin
      bk[w_lat_addr + 32'(8 * wbeat)] = w_lat_data;
      wbeat++;
      if (wbeat == 8) begin wbeat = 0; w_started = 0; end
    end
    if (!rst) begin
      wbeat = 0; w_started = 0; w_pending = 0; mem_w_ready = 1'b0;
    end else if (mem_w_valid) begin
      if (!w_started) begin
        w_started = 1; w_lat_addr = mem_w_addr; wb_q.push_back(mem_w_addr);
      end else chk("mem_w_addr_stable", 64'(mem_w_addr), 64'(w_lat_addr));
      chk("mem_w_data", mem_w_data, gm_rd(w_lat_addr + 32'(8 * wbeat)));
      if (wbeat == 0) wb_first = mem_w_data;
      mem_w_ready = (stall_ctr % 4 != 2);
      w_pending   = mem_w_ready;
      w_lat_data  = mem_w_data;
    end else begin
      mem_w_ready = 1'b0; w_pending = 0;
    end
  end

  // One LSU access; exp_lat of 0 means the latency depends on memory stalls
  task automatic access(input string nm, input bit wr, input bit both,
                        input logic [31:0] a, input logic [7:0] st, input logic [63:0] d,
                        input int exp_lat, input bit exp_rf, input logic [31:0] rf_a,
                        input bit exp_wb, input logic [31:0] wb_a);
    int cyc;
    bit ack;
    rf_q.delete();
    wb_q.delete();
    cur_addr    = a;
    lsu_addr    = a;
    lsu_w_strb  = st;
    lsu_w_data  = d;
    lsu_w_valid = wr;
    lsu_r_ready = !wr || both;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        lsu_addr   = a ^ 32'h0F00_0038;
        lsu_w_data = ~d;
        lsu_w_strb = ~st;
      end
      ack = lsu_w_ready | lsu_r_valid;
    end while (!ack && cyc < 2000);
    chk({nm, " ack"}, 64'(ack), 64'd1);
    chk({nm, " ack_kind"}, 64'(lsu_w_ready), 64'(wr));
    if (exp_lat > 0) chk({nm, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({nm, " refills"}, 64'(rf_q.size()), 64'(exp_rf));
    if (rf_q.size() > 0) chk({nm, " refill_addr"}, 64'(rf_q[0]), 64'(rf_a));
    chk({nm, " writebacks"}, 64'(wb_q.size()), 64'(exp_wb));
    if (wb_q.size() > 0) chk({nm, " wb_addr"}, 64'(wb_q[0]), 64'(wb_a));
    rd_last = lsu_r_data;
    if (wr) gm[{a[31:3], 3'b0}] = merge(gm_rd({a[31:3], 3'b0}), d, st);
    @(negedge clk);
    chk({nm, " ack_held"}, 64'(lsu_w_ready | lsu_r_valid), 64'd1);
    chk({nm, " data_held"}, lsu_r_data, rd_last);
    lsu_w_valid = 1'b0;
    lsu_r_ready = 1'b0;
    lsu_addr    = 32'hDEAD_BEE8;
    @(negedge clk);
    chk({nm, " ack_drop"}, 64'(lsu_w_ready | lsu_r_valid), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " lsu_r_valid"}, 64'(lsu_r_valid), 64'd0);
    chk({nm, " lsu_w_ready"}, 64'(lsu_w_ready), 64'd0);
    chk({nm, " mem_r_ready"}, 64'(mem_r_ready), 64'd0);
    chk({nm, " mem_w_valid"}, 64'(mem_w_valid), 64'd0);
    chk({nm, " lsu_r_data"}, lsu_r_data, 64'd0);
    chk({nm, " mem_r_addr"}, 64'(mem_r_addr), 64'd0);
    chk({nm, " mem_w_addr"}, 64'(mem_w_addr), 64'd0);
  endtask

  initial begin
    int cyc;
    #1 rst = 1'b0;
    #1 chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    access("cold_wr",  1, 0, 32'h8000_0000, 8'h01, 64'h01,       0, 1, 32'h8000_0000, 0, 0);
    access("fill_w1",  1, 0, 32'h8100_0000, 8'h02, 64'h02 << 8,  0, 1, 32'h8100_0000, 0, 0);
    access("fill_w2",  1, 0, 32'h8200_0000, 8'h04, 64'h03 << 16, 0, 1, 32'h8200_0000, 0, 0);
    access("fill_w3",  1, 0, 32'h8300_0000, 8'h08, 64'h04 << 24, 0, 1, 32'h8300_0000, 0, 0);
    access("evict_w0", 1, 0, 32'h8400_0000, 8'h10, 64'h05 << 32, 0, 1, 32'h8400_0000, 1, 32'h8000_0000);
    chk("evict_wb_beat0", wb_first, 64'h8000_0000_7FFF_FF01);
    access("evict_w1", 1, 0, 32'h8500_0000, 8'h20, 64'h06 << 40, 0, 1, 32'h8500_0000, 1, 32'h8100_0000);
    access("rd_after_evict", 0, 0, 32'h8000_0000, 8'h00, 64'h0, 0, 1, 32'h8000_0000, 1, 32'h8200_0000);
    chk("rd_after_evict_lit", rd_last, 64'h8000_0000_7FFF_FF01);
    access("rd_miss_w6", 0, 0, 32'h8600_0030, 8'h00, 64'h0, 0, 1, 32'h8600_0000, 1, 32'h8300_0000);
    chk("rd_miss_w6_lit", rd_last, 64'h8600_0030_79FF_FFCF);
    access("rd_hit_w6", 0, 0, 32'h8600_0030, 8'h00, 64'h0, 3, 0, 0, 0, 0);
    access("rd_miss_w4", 0, 0, 32'h8700_0020, 8'h00, 64'h0, 0, 1, 32'h8700_0000, 1, 32'h8400_0000);
    chk("rd_miss_w4_lit", rd_last, 64'h8700_0020_78FF_FFDF);
    access("rd_hit_w4", 0, 0, 32'h8700_0020, 8'h00, 64'h0, 3, 0, 0, 0, 0);
    access("wr_hit", 1, 0, 32'h8600_0038, 8'hFF, 64'h1122_3344_5566_7788, 3, 0, 0, 0, 0);
    access("rd_hit_w7", 0, 0, 32'h8600_0038, 8'h00, 64'h0, 3, 0, 0, 0, 0);
    chk("rd_hit_w7_lit", rd_last, 64'h1122_3344_5566_7788);
    access("set1_wr", 1, 0, 32'h8000_0040, 8'h0F, 64'hAABB_CCDD, 0, 1, 32'h8000_0040, 0, 0);
    access("set1_rd", 0, 0, 32'h8000_0040, 8'h00, 64'h0, 3, 0, 0, 0, 0);
    chk("set1_rd_lit", rd_last, 64'h8000_0040_AABB_CCDD);
    access("wr_priority", 1, 1, 32'h8000_0048, 8'hF0, 64'h1234_5678_0000_0000, 3, 0, 0, 0, 0);
    access("prio_rd", 0, 0, 32'h8000_0048, 8'h00, 64'h0, 3, 0, 0, 0, 0);
    chk("prio_rd_lit", rd_last, 64'h1234_5678_7FFF_FFB7);

    // Reset in the middle of a refill burst
    rf_q.delete();
    cur_addr    = 32'h9000_0080;
    lsu_addr    = 32'h9000_0080;
    lsu_r_ready = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!mem_r_ready && cyc < 200);
    chk("mid_refill ready_seen", 64'(mem_r_ready), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("mid_refill");
    lsu_r_ready = 1'b0;
    gm.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    access("post_rst_rd", 0, 0, 32'h9000_0080, 8'h00, 64'h0, 0, 1, 32'h9000_0080, 0, 0);
    access("post_rst_lost", 0, 0, 32'h8600_0038, 8'h00, 64'h0, 0, 1, 32'h8600_0000, 0, 0);
    chk("post_rst_lost_lit", rd_last, 64'h8600_0038_79FF_FFC7);
    access("post_rst_hit", 0, 0, 32'h8600_0038, 8'h00, 64'h0, 3, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
